// File: rtl/hop_pkg.sv
// Shared types and constants for the hop sequencer slice.
package hop_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP    = 3'd1,
    S_CALC    = 3'd2,
    S_PRESENT = 3'd3,
    S_DWELL   = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One Galois right-shift step with the feedback taps applied on a shifted-out 1.
  function automatic logic [15:0] lfsr_advance(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // A zero seed would lock the LFSR at zero, so substitute the default.
  function automatic logic [15:0] lfsr_fix_seed(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/hop_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load (priority) and step.
module hop_lfsr16 import hop_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next state: load wins over step, otherwise hold.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = lfsr_fix_seed(seed_i);
    end else if (step_i) begin
      state_d = lfsr_advance(state_q);
    end
  end

  // State register, cleared to zero on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/hop_sequencer.sv
// Pseudo-random frequency-hop sequencer: LFSR-driven channel selection,
// programmable dwell, one phase increment per hop on a valid/ready stream.
module hop_sequencer import hop_pkg::*; #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned CHAN_W  = 6,
  parameter int unsigned DWELL_W = 32
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               cfg_enable,
  input  logic [PHASE_W-1:0] cfg_base_inc,
  input  logic [PHASE_W-1:0] cfg_step_inc,
  input  logic [CHAN_W-1:0]  cfg_num_chan,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [15:0]        cfg_seed,
  output logic [PHASE_W-1:0] m_phase_inc,
  output logic [CHAN_W-1:0]  m_chan,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [31:0]        hop_count,
  output logic               busy
);

  state_e             state_q;
  logic [PHASE_W-1:0] base_q;
  logic [PHASE_W-1:0] step_q;
  logic [CHAN_W-1:0]  nchan_q;
  logic [DWELL_W-1:0] dwell_len_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [PHASE_W-1:0] phase_q;
  logic [CHAN_W-1:0]  chan_q;
  logic               valid_q;
  logic [31:0]        hop_cnt_q;

  logic [15:0]        lfsr;
  logic               lfsr_load;
  logic               lfsr_step;
  logic [CHAN_W+5:0]  prod_d;
  logic [CHAN_W-1:0]  chan_d;
  logic [PHASE_W-1:0] phase_d;

  assign lfsr_load = (state_q == S_IDLE) && cfg_enable;
  assign lfsr_step = (state_q == S_STEP);

  hop_lfsr16 u_lfsr (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (cfg_seed),
    .state_o (lfsr)
  );

  // Channel scale: top 6 LFSR bits as a fraction of n, so chan < n always.
  always_comb begin
    prod_d  = (CHAN_W+6)'(lfsr[15:10]) * (CHAN_W+6)'(nchan_q);
    chan_d  = prod_d[CHAN_W+5:6];
    phase_d = base_q + PHASE_W'(chan_d) * step_q;
  end

  // Hop FSM with registered stream outputs and hop counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      step_q      <= '0;
      nchan_q     <= '0;
      dwell_len_q <= '0;
      dwell_cnt_q <= '0;
      phase_q     <= '0;
      chan_q      <= '0;
      valid_q     <= 1'b0;
      hop_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_enable) begin
            hop_cnt_q <= '0;
            state_q   <= S_STEP;
          end
        end
        S_STEP: begin
          if (!cfg_enable) begin
            state_q <= S_IDLE;
          end else begin
            base_q      <= cfg_base_inc;
            step_q      <= cfg_step_inc;
            nchan_q     <= (cfg_num_chan == '0) ? CHAN_W'(1) : cfg_num_chan;
            dwell_len_q <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
            state_q     <= S_CALC;
          end
        end
        S_CALC: begin
          if (!cfg_enable) begin
            state_q <= S_IDLE;
          end else begin
            phase_q <= phase_d;
            chan_q  <= chan_d;
            valid_q <= 1'b1;
            state_q <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // A presented word is never withdrawn; disable only takes effect after acceptance.
          if (valid_q && m_ready) begin
            valid_q     <= 1'b0;
            hop_cnt_q   <= hop_cnt_q + 32'd1;
            dwell_cnt_q <= dwell_len_q;
            state_q     <= cfg_enable ? S_DWELL : S_IDLE;
          end
        end
        S_DWELL: begin
          if (!cfg_enable) begin
            dwell_cnt_q <= '0;
            state_q     <= S_IDLE;
          end else if (dwell_cnt_q <= DWELL_W'(1)) begin
            dwell_cnt_q <= '0;
            state_q     <= S_STEP;
          end else begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m_phase_inc = phase_q;
  assign m_chan      = chan_q;
  assign m_valid     = valid_q;
  assign hop_count   = hop_cnt_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_hop_sequencer.sv
// Scoreboard bench for hop_sequencer.
module tb_hop_sequencer;

  localparam int PHASE_W = 32;
  localparam int CHAN_W  = 6;
  localparam int DWELL_W = 32;

  logic               ACLK = 1'b0;
  logic               ARESETN = 1'b0;
  logic               cfg_enable = 1'b0;
  logic [PHASE_W-1:0] cfg_base_inc = '0;
  logic [PHASE_W-1:0] cfg_step_inc = '0;
  logic [CHAN_W-1:0]  cfg_num_chan = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [15:0]        cfg_seed = '0;
  logic [PHASE_W-1:0] m_phase_inc;
  logic [CHAN_W-1:0]  m_chan;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic [31:0]        hop_count;
  logic               busy;

  hop_sequencer #(.PHASE_W(PHASE_W), .CHAN_W(CHAN_W), .DWELL_W(DWELL_W)) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .cfg_enable   (cfg_enable),
    .cfg_base_inc (cfg_base_inc),
    .cfg_step_inc (cfg_step_inc),
    .cfg_num_chan (cfg_num_chan),
    .cfg_dwell    (cfg_dwell),
    .cfg_seed     (cfg_seed),
    .m_phase_inc  (m_phase_inc),
    .m_chan       (m_chan),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .hop_count    (hop_count),
    .busy         (busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [CHAN_W-1:0]  chan;
    logic [PHASE_W-1:0] phase;
    logic [31:0]        idx;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned rise_q[$];
  int unsigned cyc = 0;
  int unsigned hs_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic        prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference hop list for a fresh start with the given configuration.
  task automatic push_expected(input logic [15:0] seed, input logic [CHAN_W-1:0] n,
                               input logic [PHASE_W-1:0] base, input logic [PHASE_W-1:0] step,
                               input int count);
    logic [15:0] s;
    int          n_eff;
    int          c;
    exp_t        e;
    s     = (seed == 16'h0) ? 16'hACE1 : seed;
    n_eff = (n == '0) ? 1 : int'(n);
    for (int i = 0; i < count; i++) begin
      s       = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
      c       = (int'(s[15:10]) * n_eff) / 64;
      e.chan  = CHAN_W'(c);
      e.phase = base + PHASE_W'(c) * step;
      e.idx   = 32'(i);
      sb.push_back(e);
    end
  endtask

  task automatic wait_valid(input int maxc);
    int k = 0;
    while (!m_valid && k < maxc) begin
      @(negedge ACLK);
      k++;
    end
    check_eq("wait_valid", 64'(m_valid), 64'd1);
  endtask

  task automatic wait_hs(input int n, input int maxc);
    int unsigned target;
    int k = 0;
    target = hs_cnt + n;
    while (hs_cnt < target && k < maxc) begin
      @(negedge ACLK);
      k++;
    end
    check_eq("wait_handshakes", 64'(hs_cnt >= target), 64'd1);
  endtask

  task automatic check_gaps(input int count, input int expected, input int maxc);
    int k = 0;
    while (rise_q.size() < count && k < maxc) begin
      @(negedge ACLK);
      k++;
    end
    check_eq("rise_count", 64'(rise_q.size() >= count), 64'd1);
    if (rise_q.size() >= count)
      for (int i = 1; i < count; i++)
        check_eq("hop_period", 64'(rise_q[i] - rise_q[i-1]), 64'(expected));
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  // Monitor: record valid rises and compare every accepted word with the scoreboard.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      prev_valid = 1'b0;
    end else begin
      if (m_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = m_valid;
      if (m_valid && m_ready) begin
        check_eq("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check_eq("chan", 64'(m_chan), 64'(mon_e.chan));
          check_eq("phase", 64'(m_phase_inc), 64'(mon_e.phase));
          check_eq("hop_count_at_accept", 64'(hop_count), 64'(mon_e.idx));
        end
        hs_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PHASE_W-1:0] held_phase;
    logic [CHAN_W-1:0]  held_chan;
    logic [31:0]        held_hc;

    repeat (3) @(posedge ACLK);
    #1;
    check_eq("rst_valid", 64'(m_valid), 64'd0);
    check_eq("rst_phase", 64'(m_phase_inc), 64'd0);
    check_eq("rst_chan", 64'(m_chan), 64'd0);
    check_eq("rst_hop_count", 64'(hop_count), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    ARESETN = 1'b1;

    // Basic sequence and three-edge latency.
    cfg_seed = 16'h0001; cfg_num_chan = 6'd8; cfg_base_inc = 32'h1000;
    cfg_step_inc = 32'h0100; cfg_dwell = 32'd4; m_ready = 1'b1;
    push_expected(16'h0001, 6'd8, 32'h1000, 32'h0100, 40);
    rise_q.delete();
    @(posedge ACLK); #1 cfg_enable = 1'b1;
    repeat (3) @(negedge ACLK);
    check_eq("latency_before_3rd_edge", 64'(m_valid), 64'd0);
    @(negedge ACLK);
    check_eq("latency_3rd_edge", 64'(m_valid), 64'd1);
    check_eq("first_chan", 64'(m_chan), 64'd5);
    check_eq("first_phase", 64'(m_phase_inc), 64'h1500);
    check_eq("busy_running", 64'(busy), 64'd1);

    // Free-running period with ready tied high.
    check_gaps(5, 7, 100);

    // Backpressure hold.
    @(posedge ACLK); #1 m_ready = 1'b0;
    wait_valid(50);
    held_phase = m_phase_inc; held_chan = m_chan; held_hc = hop_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      check_eq("hold_valid", 64'(m_valid), 64'd1);
      check_eq("hold_phase", 64'(m_phase_inc), 64'(held_phase));
      check_eq("hold_chan", 64'(m_chan), 64'(held_chan));
    end
    @(posedge ACLK); #1 m_ready = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    check_eq("hold_accept_count", 64'(hop_count), 64'(held_hc + 32'd1));
    check_eq("valid_drop_after_accept", 64'(m_valid), 64'd0);

    // Disable while dwelling, then restart from the seed.
    cfg_enable = 1'b0;
    @(negedge ACLK);
    check_eq("disable_busy", 64'(busy), 64'd0);
    check_eq("disable_valid", 64'(m_valid), 64'd0);
    sb.delete();
    push_expected(16'h0001, 6'd8, 32'h1000, 32'h0100, 40);
    @(posedge ACLK); #1 cfg_enable = 1'b1;
    wait_hs(6, 200);

    // Zero seed, zero channels, zero dwell.
    @(posedge ACLK); #1 cfg_enable = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check_eq("idle_before_s4", 64'(busy), 64'd0);
    sb.delete();
    cfg_seed = 16'h0; cfg_num_chan = 6'd0; cfg_dwell = 32'd0;
    cfg_base_inc = 32'h2345_0000; cfg_step_inc = 32'h0000_0111;
    push_expected(16'h0, 6'd0, 32'h2345_0000, 32'h0000_0111, 40);
    rise_q.delete();
    cfg_enable = 1'b1;
    check_gaps(6, 4, 100);
    check_eq("n0_chan", 64'(m_chan), 64'd0);

    // Reset in the middle of a presented hop.
    @(posedge ACLK); #1 m_ready = 1'b0;
    wait_valid(50);
    #2 ARESETN = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(m_valid), 64'd0);
    check_eq("async_rst_phase", 64'(m_phase_inc), 64'd0);
    check_eq("async_rst_chan", 64'(m_chan), 64'd0);
    check_eq("async_rst_hop_count", 64'(hop_count), 64'd0);
    check_eq("async_rst_busy", 64'(busy), 64'd0);
    cfg_enable = 1'b0;
    sb.delete();
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    check_eq("post_rst_valid", 64'(m_valid), 64'd0);
    check_eq("post_rst_hop_count", 64'(hop_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
